// File: rtl/cp0_regs_pkg.sv
// Shared CP0 constants: register addresses, exception codes, vector addresses
// and bit positions inside the exception vector, Status and Cause.
package cp0_regs_pkg;

    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_t;

    localparam int EXCEPT_ADEL_FETCH = 6;
    localparam int EXCEPT_BP         = 5;
    localparam int EXCEPT_SYS        = 4;
    localparam int EXCEPT_RI         = 3;
    localparam int EXCEPT_OV         = 2;
    localparam int EXCEPT_ADEL_DATA  = 1;
    localparam int EXCEPT_ADES       = 0;

    localparam int STATUS_BEV = 22;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_IE  = 0;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_TI   = 30;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI is a sticky
// match flag that only a Compare write clears.
module cp0_timer
    import cp0_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            tick    <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (we && addr == CP0_COUNT) begin
                count <= wdata;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    count <= count + 32'd1;
            end
            // A Compare write beats a coincident match so software can always acknowledge
            if (we && addr == CP0_COMPARE) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file and MEM-stage exception commit: resolves
// interrupts/exceptions, updates EPC/Cause/Status/BadVAddr and redirects fetch.
module cp0_regs
    import cp0_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic        i_bd,
    input  logic [6:0]  i_except,
    input  logic [31:0] i_badvaddr,
    input  logic        i_eret,
    input  logic        mtc0_we,
    input  logic [4:0]  c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic [4:0]  c0_raddr,
    output logic [31:0] c0_rdata,
    input  logic [5:0]  ext_int,
    output logic        flush,
    output logic [31:0] exc_pc,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [1:0]  cause_ip_sw;
    logic [5:0]  ip_hw;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [7:0]  cause_ip;

    exc_code_t   exc_code;
    logic        bad_from_pc;
    logic        bad_from_data;
    logic        int_pending;
    logic        take_exc;
    logic        eret_eff;
    logic        mtc0_eff;

    assign cause_ip = {ip_hw[5] | ti, ip_hw[4:0], cause_ip_sw};

    // Priority encoder; gating with reset keeps flush low while reset is held
    always_comb begin
        exc_code      = EXC_INT;
        bad_from_pc   = 1'b0;
        bad_from_data = 1'b0;
        int_pending   = reset && i_valid && status_ie && !status_exl
                        && ((cause_ip & status_im) != 8'd0);
        if (int_pending)                       exc_code = EXC_INT;
        else if (i_except[EXCEPT_ADEL_FETCH]) begin exc_code = EXC_ADEL; bad_from_pc = 1'b1; end
        else if (i_except[EXCEPT_RI])          exc_code = EXC_RI;
        else if (i_except[EXCEPT_SYS])         exc_code = EXC_SYS;
        else if (i_except[EXCEPT_BP])          exc_code = EXC_BP;
        else if (i_except[EXCEPT_OV])          exc_code = EXC_OV;
        else if (i_except[EXCEPT_ADEL_DATA]) begin exc_code = EXC_ADEL; bad_from_data = 1'b1; end
        else if (i_except[EXCEPT_ADES])  begin exc_code = EXC_ADES; bad_from_data = 1'b1; end
        take_exc = reset && i_valid && (int_pending || i_except != 7'd0);
        eret_eff = reset && i_valid && i_eret && !take_exc;
        mtc0_eff = reset && i_valid && mtc0_we && !take_exc;
    end

    assign flush  = take_exc || eret_eff;
    assign exc_pc = eret_eff ? epc : EXC_VECTOR;

    cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .we      (mtc0_eff),
        .addr    (c0_addr),
        .wdata   (c0_wdata),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_im   <= STATUS_RESET[15:8];
            status_exl  <= STATUS_RESET[STATUS_EXL];
            status_ie   <= STATUS_RESET[STATUS_IE];
            cause_bd    <= 1'b0;
            cause_ip_sw <= 2'd0;
            ip_hw       <= 6'd0;
            cause_exc   <= 5'd0;
            epc         <= 32'd0;
            badvaddr    <= 32'd0;
        end else begin
            ip_hw <= ext_int;
            if (take_exc) begin
                // A nested exception keeps the original return point
                if (!status_exl) begin
                    epc      <= i_bd ? i_pc - 32'd4 : i_pc;
                    cause_bd <= i_bd;
                end
                cause_exc  <= exc_code;
                status_exl <= 1'b1;
                if (bad_from_pc)
                    badvaddr <= i_pc;
                else if (bad_from_data)
                    badvaddr <= i_badvaddr;
            end else begin
                if (eret_eff)
                    status_exl <= 1'b0;
                if (mtc0_eff) begin
                    case (c0_addr)
                        CP0_STATUS: begin
                            status_im  <= c0_wdata[15:8];
                            status_exl <= c0_wdata[STATUS_EXL];
                            status_ie  <= c0_wdata[STATUS_IE];
                        end
                        CP0_CAUSE: cause_ip_sw <= c0_wdata[9:8];
                        CP0_EPC:   epc         <= c0_wdata;
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign status_o = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_o  = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'd0};
    assign epc_o    = epc;

    always_comb begin
        c0_rdata = 32'd0;
        case (c0_raddr)
            CP0_BADVADDR: c0_rdata = badvaddr;
            CP0_COUNT:    c0_rdata = count;
            CP0_COMPARE:  c0_rdata = compare;
            CP0_STATUS:   c0_rdata = status_o;
            CP0_CAUSE:    c0_rdata = cause_o;
            CP0_EPC:      c0_rdata = epc;
            default:      c0_rdata = 32'd0;
        endcase
    end

endmodule
